// File: rtl/prog_loader_imem.sv
// ---------------------------------------------------------------------------
// prog_loader_imem
//   Program-load front end and instruction store for the single-cycle CPU.
//   A byte stream is packed big-endian into 32-bit words and written into an
//   internal word array. The CPU fetches combinationally through pc_addr_i
//   and is held in reset until the final byte of the image is committed.
//
//   Optional feature macro: PROG_LOADER_CHECKSUM_EN
//     defined   : chk_o is a running XOR of every committed word
//     undefined : chk_o is tied to zero and no checksum logic exists
//
// Ports
//   clk_i         clock, rising-edge
//   rst_i         asynchronous active-low reset
//   byte_valid_i  load byte presented
//   byte_i        load byte data
//   byte_last_i   final byte of the image (qualified by byte_valid_i)
//   byte_ready_o  loader accepts a byte this cycle
//   reload_i      restart loading (only honoured once the image is done)
//   pc_addr_i     CPU fetch byte address
//   instr_o       fetched instruction (0 outside the loaded image)
//   cpu_rst_o     active-low CPU reset, 1 releases the CPU
//   load_done_o   image committed
//   word_count_o  number of words committed
//   err_o         sticky overflow error
//   chk_o         checksum of committed words
//
// Handshake: a byte transfers on a rising edge where byte_valid_i and
// byte_ready_o are both high; the source holds byte_i/byte_last_i stable
// while byte_valid_i is high and byte_ready_o is low.
//
// The FSM state register state_q is the observation point for the load
// sequence (LOAD / DONE).
// ---------------------------------------------------------------------------
module prog_loader_imem #(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             byte_valid_i,
    input  logic [7:0]       byte_i,
    input  logic             byte_last_i,
    output logic             byte_ready_o,
    input  logic             reload_i,
    input  logic [31:0]      pc_addr_i,
    output logic [31:0]      instr_o,
    output logic             cpu_rst_o,
    output logic             load_done_o,
    output logic [IDX_W:0]   word_count_o,
    output logic             err_o,
    output logic [31:0]      chk_o
);

    typedef enum logic {
        S_LOAD = 1'b0,
        S_DONE = 1'b1
    } state_e;

    localparam logic [IDX_W:0] DEPTH_CNT = (IDX_W+1)'(DEPTH_WORDS);

    state_e          state_q, state_d;
    logic [1:0]      lane_q, lane_d;
    logic [31:0]     asm_q, asm_d;
    logic [IDX_W:0]  cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [31:0]     mem_q [DEPTH_WORDS];

    logic            accept;
    logic            commit;
    logic            full;
    logic            wr_en;
    logic [31:0]     merged;

    // Assembled word with the incoming byte dropped into its lane; lanes
    // not yet filled stay zero, which gives the padding on a short last word.
    always_comb begin
        merged = asm_q;
        case (lane_q)
            2'd0:    merged = {byte_i, 24'h0};
            2'd1:    merged = {asm_q[31:24], byte_i, 16'h0};
            2'd2:    merged = {asm_q[31:16], byte_i, 8'h0};
            default: merged = {asm_q[31:8], byte_i};
        endcase
    end

    assign byte_ready_o = (state_q == S_LOAD);
    assign accept       = byte_valid_i & byte_ready_o;
    assign commit       = accept & ((lane_q == 2'd3) | byte_last_i);
    assign full         = (cnt_q == DEPTH_CNT);
    assign wr_en        = commit & ~full;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [31:0] chk_q, chk_d;
`endif

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        asm_d   = asm_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        chk_d   = chk_q;
`endif
        case (state_q)
            S_LOAD: begin
                if (accept) begin
                    if (commit) begin
                        lane_d = 2'd0;
                        asm_d  = 32'h0;
                        if (full) begin
                            // Drop the word but keep draining the source.
                            err_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                            chk_d = chk_q ^ merged;
`endif
                        end
                        if (byte_last_i) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        lane_d = lane_q + 2'd1;
                        asm_d  = merged;
                    end
                end
            end
            default: begin
                if (reload_i) begin
                    state_d = S_LOAD;
                    lane_d  = 2'd0;
                    asm_d   = 32'h0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    chk_d   = 32'h0;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_LOAD;
            lane_q  <= 2'd0;
            asm_q   <= 32'h0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            chk_q   <= 32'h0;
`endif
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            asm_q   <= asm_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end

    // Word array is deliberately not reset; only committed words are visible.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[cnt_q[IDX_W-1:0]] <= merged;
        end
    end

    // Fetch: out-of-range or not-yet-written words read as NOP. A word being
    // written this cycle has index == word count, so it reads 0 until the edge.
    logic [IDX_W-1:0] rd_idx;
    logic             rd_hit;
    logic             unused_pc_bits;

    assign rd_idx         = pc_addr_i[IDX_W+1:2];
    assign rd_hit         = (pc_addr_i[31:IDX_W+2] == '0) && ({1'b0, rd_idx} < cnt_q);
    assign instr_o        = rd_hit ? mem_q[rd_idx] : 32'h0;
    assign unused_pc_bits = ^pc_addr_i[1:0];

    // cpu_rst_o follows the registered state, so it rises the cycle after
    // the edge that accepts the last byte.
    assign cpu_rst_o    = (state_q == S_DONE);
    assign load_done_o  = (state_q == S_DONE);
    assign word_count_o = cnt_q;
    assign err_o        = err_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    assign chk_o        = chk_q;
`else
    assign chk_o        = 32'h0;
`endif

endmodule

// File: tb/tb_prog_loader_imem.sv
module tb_prog_loader_imem;

    logic        clk;
    logic        rst_n;
    logic        byte_valid;
    logic [7:0]  byte_d;
    logic        byte_last;
    logic        reload;
    logic [31:0] pc;
    logic        sel;          // 0: 256-word DUT, 1: 4-word DUT

    logic        rdy_a, rdy_b;
    logic [31:0] instr_a, instr_b;
    logic        crst_a, crst_b;
    logic        done_a, done_b;
    logic [8:0]  wc_a;
    logic [2:0]  wc_b;
    logic        err_a, err_b;
    logic [31:0] chk_a, chk_b;
    logic        rdy;

    int checks;
    int errors;

    assign rdy = sel ? rdy_b : rdy_a;

    prog_loader_imem #(.DEPTH_WORDS(256), .IDX_W(8)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .byte_valid_i(byte_valid & ~sel), .byte_i(byte_d), .byte_last_i(byte_last),
        .byte_ready_o(rdy_a), .reload_i(reload & ~sel), .pc_addr_i(pc),
        .instr_o(instr_a), .cpu_rst_o(crst_a), .load_done_o(done_a),
        .word_count_o(wc_a), .err_o(err_a), .chk_o(chk_a)
    );

    prog_loader_imem #(.DEPTH_WORDS(4), .IDX_W(2)) dut4 (
        .clk_i(clk), .rst_i(rst_n),
        .byte_valid_i(byte_valid & sel), .byte_i(byte_d), .byte_last_i(byte_last),
        .byte_ready_o(rdy_b), .reload_i(reload & sel), .pc_addr_i(pc),
        .instr_o(instr_b), .cpu_rst_o(crst_b), .load_done_o(done_b),
        .word_count_o(wc_b), .err_o(err_b), .chk_o(chk_b)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    // Present a byte and leave valid high; returns 1 time unit after the
    // accepting edge so back-to-back calls stream one byte per cycle.
    task automatic send_byte(input logic [7:0] b, input logic last);
        int n;
        byte_valid = 1'b1;
        byte_d     = b;
        byte_last  = last;
        n = 0;
        @(negedge clk);
        while (!rdy && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: ready=%0b required=1", rdy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reload();
        byte_valid = 1'b0;
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    task automatic send_image8(input logic toggle);
        logic [7:0] img [8];
        img = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
        for (int i = 0; i < 8; i++) begin
            send_byte(img[i], (i == 7));
            if (toggle) idle_cycle();
        end
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #13;
        pc = 32'h0;
        #1;
        checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", rdy_a); end
        checks++; if (crst_a !== 1'b0) begin errors++; $display("FAIL reset_cpu_rst: got %0b want 0", crst_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done_a); end
        checks++; if (wc_a !== 9'd0) begin errors++; $display("FAIL reset_wc: got %0d want 0", wc_a); end
        checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", err_a); end
        checks++; if (chk_a !== 32'h0) begin errors++; $display("FAIL reset_chk: got %h want 0", chk_a); end
        checks++; if (instr_a !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", instr_a); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] img [8];
        img = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
        for (int i = 0; i < 7; i++) send_byte(img[i], 1'b0);
        checks++; if (wc_a !== 9'd1) begin errors++; $display("FAIL basic_wc_mid: got %0d want 1", wc_a); end
        checks++; if (crst_a !== 1'b0) begin errors++; $display("FAIL basic_cpu_rst_mid: got %0b want 0", crst_a); end
        send_byte(img[7], 1'b1);
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        checks++; if (crst_a !== 1'b1) begin errors++; $display("FAIL basic_cpu_rst: got %0b want 1", crst_a); end
        checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL basic_done: got %0b want 1", done_a); end
        checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL basic_ready_done: got %0b want 0", rdy_a); end
        checks++; if (wc_a !== 9'd2) begin errors++; $display("FAIL basic_wc: got %0d want 2", wc_a); end
        pc = 32'h0; #1;
        checks++; if (instr_a !== 32'h20080005) begin errors++; $display("FAIL basic_pc0: got %h want 20080005", instr_a); end
        pc = 32'h4; #1;
        checks++; if (instr_a !== 32'h20090007) begin errors++; $display("FAIL basic_pc4: got %h want 20090007", instr_a); end
        pc = 32'h7; #1;
        checks++; if (instr_a !== 32'h20090007) begin errors++; $display("FAIL basic_pc7: got %h want 20090007", instr_a); end
        pc = 32'h8; #1;
        checks++; if (instr_a !== 32'h0) begin errors++; $display("FAIL basic_pc8: got %h want 0", instr_a); end
        pc = 32'h400; #1;
        checks++; if (instr_a !== 32'h0) begin errors++; $display("FAIL basic_pc_high: got %h want 0", instr_a); end
        idle_cycle();
        checks++; if (crst_a !== 1'b1) begin errors++; $display("FAIL basic_cpu_rst_hold: got %0b want 1", crst_a); end
    endtask

    task automatic test_reload();
        pulse_reload();
        checks++; if (crst_a !== 1'b0) begin errors++; $display("FAIL reload_cpu_rst: got %0b want 0", crst_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reload_done: got %0b want 0", done_a); end
        checks++; if (wc_a !== 9'd0) begin errors++; $display("FAIL reload_wc: got %0d want 0", wc_a); end
        checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL reload_ready: got %0b want 1", rdy_a); end
        pc = 32'h0; #1;
        checks++; if (instr_a !== 32'h0) begin errors++; $display("FAIL reload_pc0: got %h want 0", instr_a); end
        pc = 32'h4; #1;
        checks++; if (instr_a !== 32'h0) begin errors++; $display("FAIL reload_pc4: got %h want 0", instr_a); end
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        // reload in LOAD has no effect
        reload = 1'b1;
        send_byte(8'h56, 1'b0);
        reload = 1'b0;
        send_byte(8'h78, 1'b1);
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        pc = 32'h0; #1;
        checks++; if (instr_a !== 32'h12345678) begin errors++; $display("FAIL reload_img: got %h want 12345678", instr_a); end
        checks++; if (wc_a !== 9'd1) begin errors++; $display("FAIL reload_img_wc: got %0d want 1", wc_a); end
        checks++; if (crst_a !== 1'b1) begin errors++; $display("FAIL reload_img_cpu_rst: got %0b want 1", crst_a); end
`ifdef PROG_LOADER_CHECKSUM_EN
        checks++; if (chk_a !== 32'h12345678) begin errors++; $display("FAIL reload_chk: got %h want 12345678", chk_a); end
`else
        checks++; if (chk_a !== 32'h0) begin errors++; $display("FAIL reload_chk: got %h want 0", chk_a); end
`endif
    endtask

    task automatic test_toggle_valid();
        pulse_reload();
        send_image8(1'b1);
        checks++; if (wc_a !== 9'd2) begin errors++; $display("FAIL toggle_wc: got %0d want 2", wc_a); end
        pc = 32'h0; #1;
        checks++; if (instr_a !== 32'h20080005) begin errors++; $display("FAIL toggle_pc0: got %h want 20080005", instr_a); end
        pc = 32'h4; #1;
        checks++; if (instr_a !== 32'h20090007) begin errors++; $display("FAIL toggle_pc4: got %h want 20090007", instr_a); end
`ifdef PROG_LOADER_CHECKSUM_EN
        checks++; if (chk_a !== 32'h00010002) begin errors++; $display("FAIL toggle_chk: got %h want 00010002", chk_a); end
`endif
    endtask

    task automatic test_partial_word();
        logic [7:0] img [5];
        img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        pulse_reload();
        for (int i = 0; i < 5; i++) send_byte(img[i], (i == 4));
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        checks++; if (wc_a !== 9'd2) begin errors++; $display("FAIL partial_wc: got %0d want 2", wc_a); end
        pc = 32'h0; #1;
        checks++; if (instr_a !== 32'hAABBCCDD) begin errors++; $display("FAIL partial_pc0: got %h want aabbccdd", instr_a); end
        pc = 32'h4; #1;
        checks++; if (instr_a !== 32'hEE000000) begin errors++; $display("FAIL partial_pc4: got %h want ee000000", instr_a); end
`ifdef PROG_LOADER_CHECKSUM_EN
        checks++; if (chk_a !== 32'h44BBCCDD) begin errors++; $display("FAIL partial_chk: got %h want 44bbccdd", chk_a); end
`else
        checks++; if (chk_a !== 32'h0) begin errors++; $display("FAIL partial_chk: got %h want 0", chk_a); end
`endif
    endtask

    task automatic test_empty_image();
        pulse_reload();
        send_byte(8'h5A, 1'b1);
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        checks++; if (wc_a !== 9'd1) begin errors++; $display("FAIL empty_wc: got %0d want 1", wc_a); end
        checks++; if (crst_a !== 1'b1) begin errors++; $display("FAIL empty_cpu_rst: got %0b want 1", crst_a); end
        pc = 32'h0; #1;
        checks++; if (instr_a !== 32'h5A000000) begin errors++; $display("FAIL empty_pc0: got %h want 5a000000", instr_a); end
    endtask

    task automatic test_reset_mid_load();
        pulse_reload();
        for (int i = 0; i < 6; i++) send_byte(8'(8'h40 + i), 1'b0);
        byte_valid = 1'b0;
        checks++; if (wc_a !== 9'd1) begin errors++; $display("FAIL rstmid_wc_before: got %0d want 1", wc_a); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (wc_a !== 9'd0) begin errors++; $display("FAIL rstmid_wc: got %0d want 0", wc_a); end
        checks++; if (crst_a !== 1'b0) begin errors++; $display("FAIL rstmid_cpu_rst: got %0b want 0", crst_a); end
        checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %0b want 1", rdy_a); end
        pc = 32'h0; #1;
        checks++; if (instr_a !== 32'h0) begin errors++; $display("FAIL rstmid_pc0: got %h want 0", instr_a); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_image8(1'b0);
        checks++; if (wc_a !== 9'd2) begin errors++; $display("FAIL rstmid_reload_wc: got %0d want 2", wc_a); end
        pc = 32'h0; #1;
        checks++; if (instr_a !== 32'h20080005) begin errors++; $display("FAIL rstmid_pc0_new: got %h want 20080005", instr_a); end
        pc = 32'h4; #1;
        checks++; if (instr_a !== 32'h20090007) begin errors++; $display("FAIL rstmid_pc4_new: got %h want 20090007", instr_a); end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_w [4];
        exp_w = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
        sel = 1'b1;
        for (int i = 0; i < 16; i++) send_byte(8'(i + 1), 1'b0);
        checks++; if (wc_b !== 3'd4) begin errors++; $display("FAIL ovf_wc_full: got %0d want 4", wc_b); end
        checks++; if (err_b !== 1'b0) begin errors++; $display("FAIL ovf_err_early: got %0b want 0", err_b); end
        for (int i = 16; i < 20; i++) send_byte(8'(i + 1), (i == 19));
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        checks++; if (err_b !== 1'b1) begin errors++; $display("FAIL ovf_err: got %0b want 1", err_b); end
        checks++; if (wc_b !== 3'd4) begin errors++; $display("FAIL ovf_wc: got %0d want 4", wc_b); end
        checks++; if (crst_b !== 1'b1) begin errors++; $display("FAIL ovf_cpu_rst: got %0b want 1", crst_b); end
        for (int i = 0; i < 4; i++) begin
            pc = 32'(i * 4); #1;
            checks++;
            if (instr_b !== exp_w[i]) begin
                errors++;
                $display("FAIL ovf_mem%0d: got %h want %h", i, instr_b, exp_w[i]);
            end
        end
        pc = 32'h10; #1;
        checks++; if (instr_b !== 32'h0) begin errors++; $display("FAIL ovf_pc_high: got %h want 0", instr_b); end
`ifdef PROG_LOADER_CHECKSUM_EN
        checks++; if (chk_b !== 32'h00000010) begin errors++; $display("FAIL ovf_chk: got %h want 00000010", chk_b); end
`endif
        pulse_reload();
        checks++; if (err_b !== 1'b0) begin errors++; $display("FAIL ovf_err_clear: got %0b want 0", err_b); end
        checks++; if (wc_b !== 3'd0) begin errors++; $display("FAIL ovf_wc_clear: got %0d want 0", wc_b); end
        sel = 1'b0;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        byte_valid = 1'b0;
        byte_d     = 8'h0;
        byte_last  = 1'b0;
        reload     = 1'b0;
        pc         = 32'h0;
        sel        = 1'b0;
        test_reset();
        @(posedge clk); #1;
        test_basic();
        test_reload();
        test_toggle_valid();
        test_partial_word();
        test_empty_image();
        test_reset_mid_load();
        test_overflow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_loader_imem.md
Name: prog_loader_imem

Overview:
- Program-load front end and instruction store for the single-cycle CPU. It is the writer side of the CPU's instruction-fetch read port.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words into an internal word array.
- Serves combinational fetch reads on pc_addr_i.
- Holds the CPU in reset (cpu_rst_o low) until the final byte is committed.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the store (power of two, 4..4096).
- IDX_W, 8, word index width; must equal log2(DEPTH_WORDS).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- byte_valid_i  input  1  a load byte is presented.
- byte_i  input  8  load byte data.
- byte_last_i  input  1  qualifies the final byte of the image; sampled with byte_valid_i.
- byte_ready_o  output  1  loader accepts a byte this cycle.
- reload_i  input  1  in DONE, restart the load sequence.
- pc_addr_i  input  32  CPU fetch byte address.
- instr_o  output  32  fetched instruction.
- cpu_rst_o  output  1  active-low reset to the CPU; 1 releases the CPU.
- load_done_o  output  1  image committed.
- word_count_o  output  IDX_W+1  words committed.
- err_o  output  1  sticky overflow error.
- chk_o  output  32  checksum (see Optional Feature).

Behaviour:
- Reset (rst_i=0, asynchronous):
  - FSM goes to LOAD; byte_ready_o=1 after release.
  - cpu_rst_o=0, load_done_o=0, word_count_o=0, err_o=0, chk_o=0.
  - Byte lane counter=0, assembly register=0.
  - Word array contents are not cleared.
- Byte handshake: a byte is accepted on a rising edge where byte_valid_i & byte_ready_o. byte_i and byte_last_i must be held while valid is high and ready is low.
- Word assembly:
  - Byte lane 0 goes to bits 31:24, lane 1 to 23:16, lane 2 to 15:8, lane 3 to 7:0.
  - On acceptance of lane 3, the word is written to mem[word_count] on that same edge, word_count increments, and the lane counter wraps to 0.
- byte_last_i on a partial word (lane 0..2): the word is committed with unfilled lanes zero-padded, on the same edge.
- Overflow:
  - If word_count==DEPTH_WORDS when a word would commit, the write is dropped and err_o is set (sticky until reset or reload).
  - Bytes keep being accepted so the source drains.
- FSM:
  - LOAD -> DONE on the edge accepting byte_last_i.
  - DONE: byte_ready_o=0, load_done_o=1, cpu_rst_o=1. cpu_rst_o rises on the first cycle after that edge (registered).
  - DONE -> LOAD when reload_i=1. On that edge: cpu_rst_o=0, load_done_o=0, word_count=0, lane=0, err_o=0, chk_o=0.
  - reload_i is ignored in LOAD.
- Fetch read (combinational, zero latency):
  - index = pc_addr_i[IDX_W+1:2].
  - instr_o = mem[index] if pc_addr_i[31:IDX_W+2]==0 and index<word_count; otherwise 32'h0 (NOP).
  - pc_addr_i[1:0] is ignored.
- Simultaneous read and write of the same index: instr_o shows the old value (0, since index==word_count) until the edge completes.
- Reset mid-load: all state is discarded; a partially assembled word is lost.
- Empty image: a single byte with byte_last_i on lane 0 commits one word 0xBB000000 (BB = the byte).

Optional Feature:
- Macro PROG_LOADER_CHECKSUM_EN.
- Defined: chk_o is a running 32-bit XOR of every committed word, including the padded final word. Dropped overflow words are excluded. chk_o is cleared on reset and reload.
- Undefined: chk_o is constant 32'h0 and no checksum logic is built.

Test Plan:
- Reset, stream 8 bytes 20 08 00 05 20 09 00 07 (last on the 8th), always valid:
  - mem[0]=0x20080005, mem[1]=0x20090007, word_count_o=2.
  - cpu_rst_o=1 one cycle after the last byte.
  - instr_o at pc 0x4 = 0x20090007; at pc 0x8 = 0.
- Same stream with byte_valid_i toggled every other cycle: identical words. Bytes are accepted only on valid&ready cycles.
- 5 bytes AA BB CC DD EE, last on EE:
  - mem[1]=0xEE000000, word_count_o=2.
  - With the macro defined: chk_o=0xAABBCCDD^0xEE000000=0x44BBCCDD.
- DEPTH_WORDS=4, stream 20 bytes:
  - err_o=1 after the 5th word; word_count_o=4; mem[0..3] intact.
  - cpu_rst_o=1 after the last byte.
- In DONE assert reload_i:
  - cpu_rst_o=0, word_count_o=0, instr_o=0 for all pc.
  - A new 4-byte image loads correctly.
- Assert rst_i=0 mid-way through the 2nd word:
  - Outputs return to reset values asynchronously.
  - A subsequent full image loads from word 0.
